// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives a synchronous-read instruction memory and hands
// {inst, pc, valid} to decode. Redirects arrive from execute and are ignored while stalled.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h4000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        pc_sel,
  input  logic [31:0] branch_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_dout,
  output logic [31:0] decode_inst,
  output logic [31:0] decode_pc,
  output logic        decode_valid,
  output logic        fetch_misaligned,
  output logic [31:0] fetch_count
);

  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic        misaligned_q, misaligned_d;
  logic [31:0] count_q, count_d;
  logic [31:0] next_pc;
  logic        redirect;

  assign redirect = pc_sel & ~stall;

  always_comb begin
    next_pc = pc_q + 32'd4;
    if (rst) begin
      next_pc = RESET_PC;
    end else if (redirect) begin
      next_pc = {branch_target[31:2], 2'b00};
    end else if (stall) begin
      // Re-present the held address so imem_dout stays stable without a skid buffer.
      next_pc = pc_q;
    end
  end

  always_comb begin
    pc_d         = next_pc;
    valid_d      = 1'b1;
    misaligned_d = misaligned_q | (redirect & (|branch_target[1:0]));
    count_d      = count_q;
    if (valid_q && !stall) begin
      count_d = count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // One word before RESET_PC so the first post-reset next_pc is RESET_PC itself.
      pc_q         <= RESET_PC - 32'd4;
      valid_q      <= 1'b0;
      misaligned_q <= 1'b0;
      count_q      <= 32'd0;
    end else begin
      pc_q         <= pc_d;
      valid_q      <= valid_d;
      misaligned_q <= misaligned_d;
      count_q      <= count_d;
    end
  end

  assign imem_addr        = next_pc;
  assign decode_pc        = pc_q;
  assign decode_valid     = valid_q;
  assign decode_inst      = valid_q ? imem_dout : NOP_INST;
  assign fetch_misaligned = misaligned_q;
  assign fetch_count      = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset, redirect, stall, stall-vs-redirect, misaligned target,
// address wrap and mid-run reset, against a small synchronous-read memory.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        pc_sel;
  logic [31:0] branch_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_dout;
  logic [31:0] decode_inst;
  logic [31:0] decode_pc;
  logic        decode_valid;
  logic        fetch_misaligned;
  logic [31:0] fetch_count;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  fetch_stage dut (
    .clk              (clk),
    .rst              (rst),
    .stall            (stall),
    .pc_sel           (pc_sel),
    .branch_target    (branch_target),
    .imem_addr        (imem_addr),
    .imem_dout        (imem_dout),
    .decode_inst      (decode_inst),
    .decode_pc        (decode_pc),
    .decode_valid     (decode_valid),
    .fetch_misaligned (fetch_misaligned),
    .fetch_count      (fetch_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (a == 32'h4000_0000) return 32'h0000_0093;
    if (a == 32'h4000_0004) return 32'h0010_0113;
    return {a[31:2], 2'b00} ^ 32'hA5A5_A5A5;
  endfunction

  always @(posedge clk) imem_dout <= mem_rd(imem_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_dec(input string tag, input logic [31:0] pc, input logic [31:0] cnt);
    chk({tag, "_valid"}, {31'd0, decode_valid}, 32'd1);
    chk({tag, "_pc"}, decode_pc, pc);
    chk({tag, "_inst"}, decode_inst, mem_rd(pc));
    chk({tag, "_count"}, fetch_count, cnt);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; pc_sel = 1'b0; branch_target = 32'd0;
    cyc(); cyc(); cyc();
    chk("rst_valid", {31'd0, decode_valid}, 32'd0);
    chk("rst_inst", decode_inst, 32'h0000_0013);
    chk("rst_pc", decode_pc, 32'h3FFF_FFFC);
    chk("rst_mis", {31'd0, fetch_misaligned}, 32'd0);
    chk("rst_count", fetch_count, 32'd0);
    chk("rst_addr", imem_addr, 32'h4000_0000);

    // Cycle 0: one bubble after reset.
    rst = 1'b0; #1;
    chk("c0_addr", imem_addr, 32'h4000_0000);
    chk("c0_valid", {31'd0, decode_valid}, 32'd0);
    chk("c0_inst", decode_inst, 32'h0000_0013);
    cyc();
    chk("c1_inst_lit", decode_inst, 32'h0000_0093);
    chk_dec("c1", 32'h4000_0000, 32'd0);
    cyc();
    chk("c2_inst_lit", decode_inst, 32'h0010_0113);
    chk_dec("c2", 32'h4000_0004, 32'd1);
    cyc();
    chk_dec("c3", 32'h4000_0008, 32'd2);

    // Redirect to 0x4000_0100.
    pc_sel = 1'b1; branch_target = 32'h4000_0100; #1;
    chk("redir_addr", imem_addr, 32'h4000_0100);
    cyc(); pc_sel = 1'b0;
    chk_dec("redir_t1", 32'h4000_0100, 32'd3);
    cyc();
    chk_dec("redir_t2", 32'h4000_0104, 32'd4);
    chk("redir_mis", {31'd0, fetch_misaligned}, 32'd0);

    // Stall three cycles, frozen through the release cycle.
    stall = 1'b1; #1;
    chk("stall_addr0", imem_addr, 32'h4000_0104);
    cyc();
    chk_dec("stall1", 32'h4000_0104, 32'd4);
    chk("stall_addr1", imem_addr, 32'h4000_0104);
    cyc();
    chk_dec("stall2", 32'h4000_0104, 32'd4);
    cyc(); stall = 1'b0; #1;
    chk_dec("stall_rel", 32'h4000_0104, 32'd4);
    chk("stall_rel_addr", imem_addr, 32'h4000_0108);
    cyc();
    chk_dec("post_stall", 32'h4000_0108, 32'd5);

    // Stall dominates redirect; redirect re-asserted after release.
    stall = 1'b1; pc_sel = 1'b1; branch_target = 32'h0000_0100; #1;
    chk("svr_addr", imem_addr, 32'h4000_0108);
    cyc(); stall = 1'b0; #1;
    chk_dec("svr_hold", 32'h4000_0108, 32'd5);
    chk("svr_addr2", imem_addr, 32'h0000_0100);
    cyc(); pc_sel = 1'b0;
    chk_dec("svr_tgt", 32'h0000_0100, 32'd6);
    chk("svr_mis", {31'd0, fetch_misaligned}, 32'd0);

    // Misaligned target is force-aligned and flagged stickily.
    pc_sel = 1'b1; branch_target = 32'h4000_0202; #1;
    chk("mis_addr", imem_addr, 32'h4000_0200);
    cyc(); pc_sel = 1'b0;
    chk_dec("mis_t1", 32'h4000_0200, 32'd7);
    chk("mis_flag1", {31'd0, fetch_misaligned}, 32'd1);
    cyc();
    chk("mis_flag2", {31'd0, fetch_misaligned}, 32'd1);
    chk_dec("mis_t2", 32'h4000_0204, 32'd8);

    // PC wrap from 0xFFFF_FFFC to 0.
    pc_sel = 1'b1; branch_target = 32'hFFFF_FFFC;
    cyc(); pc_sel = 1'b0;
    chk_dec("wrap_t1", 32'hFFFF_FFFC, 32'd9);
    cyc();
    chk_dec("wrap_t2", 32'h0000_0000, 32'd10);
    chk("wrap_mis", {31'd0, fetch_misaligned}, 32'd1);

    // Mid-run reset with a concurrent redirect that must be lost.
    rst = 1'b1; pc_sel = 1'b1; branch_target = 32'h0000_0200; #1;
    chk("mrst_addr", imem_addr, 32'h4000_0000);
    cyc(); rst = 1'b0; pc_sel = 1'b0;
    chk("mrst_count", fetch_count, 32'd0);
    chk("mrst_valid", {31'd0, decode_valid}, 32'd0);
    chk("mrst_mis", {31'd0, fetch_misaligned}, 32'd0);
    chk("mrst_inst", decode_inst, 32'h0000_0013);
    chk("mrst_pc", decode_pc, 32'h3FFF_FFFC);
    cyc();
    chk_dec("mrst_first", 32'h4000_0000, 32'd0);
    chk("mrst_first_lit", decode_inst, 32'h0000_0093);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the three-stage RISC-V core. It owns the program counter, drives the synchronous-read instruction memory and presents the fetched instruction, its PC and a valid bit to the decode stage. It consumes the redirect (`pc_sel`) and the branch/jump target produced in execute. It sits directly upstream of the pipeline control unit, whose `decode_inst` input it feeds.

## Interface
- `RESET_PC`, 32'h4000_0000: address of the first fetched instruction after reset (BIOS base).
- `NOP_INST`, 32'h0000_0013: instruction driven on `decode_inst` whenever `decode_valid` is 0 (`addi x0,x0,0`).

Ports:
- `clk` in 1: core clock. One clock domain; every register updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `stall` in 1: freeze request from downstream. While high, the stage holds all state.
- `pc_sel` in 1: redirect from control. Qualified internally by `~stall`.
- `branch_target` in 32: redirect byte address from the execute ALU.
- `imem_addr` out 32: byte address to instruction memory. Combinational.
- `imem_dout` in 32: instruction memory read data. Valid one cycle after the address is presented.
- `decode_inst` out 32: instruction to decode.
- `decode_pc` out 32: PC of `decode_inst`.
- `decode_valid` out 1: `decode_inst` is a real fetched instruction.
- `fetch_misaligned` out 1: sticky flag. Set when a redirect target had `[1:0]` != 0.
- `fetch_count` out 32: number of instructions handed to decode.

## Operation
State:
- `pc_q` (32): PC of the word currently on `imem_dout`.
- `valid_q` (1)
- `misaligned_q` (1)
- `count_q` (32)

`next_pc` priority, highest first:
- `rst` -> `RESET_PC`
- `pc_sel & ~stall` -> {`branch_target[31:2]`, 2'b00}
- `stall` -> `pc_q`
- otherwise -> `pc_q + 4`, modulo 2^32 (wraps 32'hFFFF_FFFC -> 0)

Address and register updates:
- `imem_addr = next_pc`. During `stall` the current address is re-presented, so `imem_dout` stays stable with no skid buffer.
- `pc_q <= next_pc` every cycle, except on reset: `pc_q <= RESET_PC - 4` and `imem_addr = RESET_PC`. This makes the first post-reset `next_pc` equal `RESET_PC`.
- `valid_q`: cleared by reset; set to 1 on the first non-reset edge; never cleared by redirect or stall.
- Wrong-path squash is not done here. The instruction in decode during a redirect cycle is killed by control clearing its execute-valid bit.

Decode outputs:
- `decode_pc = pc_q`
- `decode_valid = valid_q`
- `decode_inst = valid_q ? imem_dout : NOP_INST`

Misalignment:
- `misaligned_q` is set when `pc_sel & ~stall & |branch_target[1:0]`.
- It is cleared only by reset.
- The target is still used, force-aligned.

Counter:
- `count_q` increments when `valid_q & ~stall`.
- It wraps at 2^32 and is cleared by reset.

Simultaneous events:
- `rst` dominates `stall` and `pc_sel`.
- `stall` dominates `pc_sel`, so the redirect is dropped. Execute holds its branch, so `pc_sel` re-asserts after the stall releases.

## Timing
- Reset values:
  - `decode_valid` = 0
  - `decode_inst` = `NOP_INST`
  - `decode_pc` = `RESET_PC - 4`
  - `fetch_misaligned` = 0
  - `fetch_count` = 0
  - `imem_addr` = `RESET_PC` while `rst` is high
- First cycle after `rst` falls (cycle 0):
  - `imem_addr` = `RESET_PC`
  - `decode_valid` = 0
- Cycle 1: `decode_inst` = mem[`RESET_PC`], `decode_pc` = `RESET_PC`, `decode_valid` = 1. This is one bubble after reset.
- Sequential fetch throughput is one instruction per cycle. `decode_pc` advances by 4 each unstalled cycle.
- Redirect with `pc_sel` in cycle t (unstalled):
  - `imem_addr` = target in cycle t.
  - Cycle t+1: `decode_pc` = target and `decode_inst` = mem[target].
  - Redirect latency is 1 cycle, with one wrong-path slot in decode during cycle t.
- Stall in cycles t..t+k: `decode_inst`, `decode_pc`, `decode_valid` and `fetch_count` are frozen through cycle t+k+1, with `decode_inst` re-read from the same address. `decode_pc` advances at the first edge after `stall` falls.
- Reset asserted mid-stream: at the next edge the state returns to the reset values, and any pending redirect is lost.
- `fetch_count` reflects accepted instructions one cycle after acceptance.

## Test plan
- **Reset sequence:** hold `rst` 3 cycles with mem[0x4000_0000]=0x0000_0093 and mem[0x4000_0004]=0x0010_0113 -> cycle 0 `decode_valid`=0 and `decode_inst`=0x13. Cycle 1: inst 0x0000_0093, pc 0x4000_0000. Cycle 2: inst 0x0010_0113, pc 0x4000_0004.
- **Redirect:** `pc_sel`=1 with target 0x4000_0100 in the cycle `decode_pc`=0x4000_0008 -> next cycle `decode_pc`=0x4000_0100, then 0x4000_0104. `fetch_misaligned` stays 0.
- **Stall:** assert `stall` for 3 cycles while `decode_pc`=0x4000_000C -> `decode_pc`, `decode_inst` and `fetch_count` are constant for 3 cycles. `imem_addr`=0x4000_000C throughout. After release, `decode_pc`=0x4000_0010.
- **Stall vs redirect:** `stall`=1 and `pc_sel`=1 with target 0x100 together -> PC holds. Next cycle `stall`=0, `pc_sel`=1 -> following cycle `decode_pc`=0x100.
- **Misaligned target:** `pc_sel` with target 0x4000_0202 -> `decode_pc`=0x4000_0200. `fetch_misaligned`=1 until the next `rst`.
- **Wrap and reset mid-run:** redirect to 0xFFFF_FFFC -> next `decode_pc`=0x0000_0000. Assert `rst` 1 cycle -> `fetch_count`=0 and `decode_valid`=0, and the first instruction is from `RESET_PC` two cycles later.
